// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the two-requester saturating add/sub arbiter.
package addsub_arbiter_pkg;

    // The controller is IDLE when nothing is held and HOLD while a result waits for its owner.
    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } state_e;

    // Bit positions within the [N V Z] flag vector.
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_Z = 0;

    // Saturation values used on signed overflow.
    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/addsub_16bit.sv
// Combinational 16-bit saturating add/subtract that produces [N V Z] flags.
module addsub_16bit
    import addsub_arbiter_pkg::*;
(
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic        is_sub,
    output logic [15:0] sum_out,
    output logic [2:0]  flag
);

    logic [16:0] a_x;
    logic [16:0] b_x;
    logic [16:0] raw;
    logic        ovf;

    // A 17-bit sign-extended result exposes overflow as a mismatch of its top two bits.
    always_comb begin
        a_x     = {a_in[15], a_in};
        b_x     = {b_in[15], b_in};
        raw     = is_sub ? (a_x - b_x) : (a_x + b_x);
        ovf     = raw[16] ^ raw[15];
        sum_out = ovf ? (raw[16] ? SAT_NEG : SAT_POS) : raw[15:0];
        flag         = '0;
        flag[FLAG_N] = sum_out[15];
        flag[FLAG_V] = ovf;
        flag[FLAG_Z] = (sum_out == 16'h0000);
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one saturating add/sub unit between two requesters.
// Results are held until the owning requester accepts them; only req0 may update flags_q.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FLAG_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_sub,
    input  logic              req0_setf,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_sub,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_sum,
    output logic [FLAG_W-1:0] rsp_flag,
    output logic [FLAG_W-1:0] flags_q
);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                pri_q, pri_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic [FLAG_W-1:0]   flag_q, flag_d;
    logic [FLAG_W-1:0]   flags_d;

    logic                grant0, grant1;
    logic                owner_rdy;
    logic                can_accept;
    logic                accept;
    logic [DATA_W-1:0]   mux_a, mux_b;
    logic                mux_sub;
    logic [DATA_W-1:0]   alu_sum;
    logic [FLAG_W-1:0]   alu_flag;

    // Grant, readiness and the operand mux; the winner is req1 exactly when grant1 is set.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | ~pri_q);
        grant1     = req1_valid & (~req0_valid | pri_q);
        owner_rdy  = owner_q ? rsp1_ready : rsp0_ready;
        can_accept = (state_q == StIdle) | ((state_q == StHold) & owner_rdy);
        // Readies are forced low during reset even though the state is already IDLE.
        req0_ready = rst_n & grant0 & can_accept;
        req1_ready = rst_n & grant1 & can_accept;
        accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        mux_a      = grant1 ? req1_a : req0_a;
        mux_b      = grant1 ? req1_b : req0_b;
        mux_sub    = grant1 ? req1_sub : req0_sub;
    end

    addsub_16bit u_addsub (
        .a_in    (mux_a),
        .b_in    (mux_b),
        .is_sub  (mux_sub),
        .sum_out (alu_sum),
        .flag    (alu_flag)
    );

    // Next-state for the FSM, result registers, priority pointer and architectural flags.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        pri_d   = pri_q;
        sum_d   = sum_q;
        flag_d  = flag_q;
        flags_d = flags_q;
        if (accept) begin
            // A same-cycle response handshake frees the slot, so overwriting is safe.
            state_d = StHold;
            owner_d = grant1;
            pri_d   = ~grant1;
            sum_d   = alu_sum;
            flag_d  = alu_flag;
            if (!grant1 && req0_setf) begin
                flags_d = alu_flag;
            end
        end else if ((state_q == StHold) && owner_rdy) begin
            state_d = StIdle;
        end
    end

    // State registers; reset discards any held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            pri_q   <= 1'b0;
            sum_q   <= '0;
            flag_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            pri_q   <= pri_d;
            sum_q   <= sum_d;
            flag_q  <= flag_d;
            flags_q <= flags_d;
        end
    end

    // Response channel outputs follow the held result and its owner.
    always_comb begin
        rsp0_valid = (state_q == StHold) & ~owner_q;
        rsp1_valid = (state_q == StHold) & owner_q;
        rsp_sum    = sum_q;
        rsp_flag   = flag_q;
    end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one saturating 16-bit add/sub unit between two requesters: req0 is the ALU issue path and req1 is the address/auxiliary path.
- Uses round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Registers each result and its [N V Z] flags, and holds them until the owning requester accepts them.
- Keeps the architectural flag register, which only req0 operations may update.

Parameters:
DATA_W, 16, operand/result width (only 16 is supported; the parameter exists for documentation and checks)
FLAG_W, 3, flag vector width, ordered [N V Z]

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready
req0_a  in  16  operand A
req0_b  in  16  operand B
req0_sub  in  1  1 = A-B, 0 = A+B
req0_setf  in  1  1 = update flags_q with this operation's flags
req1_valid  in  1  requester 1 has an operation
req1_ready  out  1  requester 1 accept
req1_a  in  16  operand A
req1_b  in  16  operand B
req1_sub  in  1  1 = A-B
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 takes the result
rsp1_valid  out  1  result for requester 1 available
rsp1_ready  in  1  requester 1 takes the result
rsp_sum  out  16  registered result, shared by both response channels
rsp_flag  out  3  registered [N V Z] of rsp_sum
flags_q  out  3  architectural flag register [N V Z]

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, owner=0, pri=0, rsp_sum=0, rsp_flag=0, flags_q=0.
  - All ready/valid outputs are 0 while rst_n=0.
  - An in-flight held result is discarded and never returned.
- Arithmetic (combinational, on the granted operands):
  - Two's-complement A+B or A-B.
  - On signed overflow the result saturates: positive overflow to 0x7FFF, negative overflow to 0x8000, and V=1.
  - N = result[15]; Z = (result==0). Flags always describe the saturated result.
- States:
  - IDLE: no result held.
  - HOLD: result held for `owner`.
- Grant:
  - Exactly one valid requester: that requester wins.
  - Both valid: the requester indicated by pri wins.
  - After every accept, pri = ~winner.
- Ready:
  - reqN_ready = grantN & (state==IDLE | (state==HOLD & rsp_owner_ready)).
  - rsp_owner_ready is the rsp ready of the current owner. This is a combinational path from rsp*_ready to req*_ready and is intentional.
- Accept (valid&ready at edge N):
  - rsp_sum, rsp_flag and owner load at edge N; state=HOLD.
  - rspX_valid=1 from cycle N+1, so latency is 1 cycle.
  - Back-to-back accepts sustain one op per cycle when the owner's rsp_ready is held high.
- HOLD:
  - rsp{owner}_valid=1; the other rsp valid is 0.
  - rsp_sum and rsp_flag are stable until the handshake completes.
  - On the owner's rsp ready with no new accept: state goes to IDLE and rsp_sum/rsp_flag retain their last values.
  - rsp ready from the non-owner is ignored.
- flags_q:
  - Loads rsp_flag's new value at the accept edge only when the winner is req0 and req0_setf=1.
  - req1 operations never modify flags_q.
- Requests must hold their operands stable while valid and not ready. The block does not check this.
- Simultaneous rsp handshake and new accept in the same cycle: the new result overwrites the old, which is legal because the old one was consumed that cycle.

Decomposition:
- Shared package holds:
  - state encoding IDLE/HOLD
  - flag bit indices FLAG_N=2, FLAG_V=1, FLAG_Z=0
  - saturation constants SAT_POS=16'h7FFF, SAT_NEG=16'h8000
- One sub-module, the existing addsub_16bit, instantiated once with:
  - a_in/b_in/is_sub driven by the grant mux
  - sum_out/flag feeding the result registers
- Arbitration, FSM and the flag register stay in addsub_arbiter.

Test Plan:
- Flag update from req0: req0 a=16'h8000, b=16'h0001, sub=1, setf=1, req1 idle.
  -> req0_ready=1 at once; next cycle rsp0_valid=1, rsp_sum=16'h8000, rsp_flag=3'b110, flags_q=3'b110.
- Contention after reset: req0 7FFF+0001 and req1 0005-0005 both valid.
  -> req0 served first (rsp 16'h7FFF, flag 3'b010); req1 next (rsp 16'h0000, flag 3'b001).
  -> flags_q changes only for the req0 op.
- Backpressure: hold rsp0_ready=0 for 3 cycles with req1 valid.
  -> rsp0_valid, rsp_sum and rsp_flag stable; req1_ready=0; req1 accepted in the cycle rsp0_ready rises.
- Streaming: req1 valid every cycle with 1+1, 2+1, 3+1 and rsp1_ready=1.
  -> rsp1_valid continuous with rsp_sum 0002, 0003, 0004 on consecutive cycles.
- Round robin: both requesters valid for 4 accepts.
  -> grant order 0,1,0,1.
- Async reset in HOLD: drop rst_n mid-cycle.
  -> rsp*_valid and flags_q go to 0 before the next edge; after release, IDLE with pri=0.
